// File: rtl/rggen_protect_pkg.sv
// Shared types and helpers for protected register bit fields.
// Covers the protection-mode selector, the key-window FSM states and the masked-write merge.
package rggen_protect_pkg;

  typedef enum logic [1:0] {
    PROTECT_LOCK   = 2'd0,
    PROTECT_ENABLE = 2'd1,
    PROTECT_KEY    = 2'd2
  } protect_mode_e;

  typedef enum logic {
    KEY_IDLE = 1'b0,
    KEY_OPEN = 1'b1
  } key_state_e;

  // Widest field is 64 bits; callers cast the result back to their own width.
  function automatic logic [63:0] get_masked_write(
    input logic [63:0] value,
    input logic [63:0] data,
    input logic [63:0] mask
  );
    return (value & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/rggen_key_window.sv
// Key unlock window: a good key opens a write window of KEY_WINDOW cycles that
// closes on the first field write, on a bad key, or when the down-counter expires.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   KEY_IDLE | field writes rejected; waiting for a full-mask good key
//   KEY_OPEN | one field write allowed; cnt_q cycles remain after this one
module rggen_key_window
  import rggen_protect_pkg::*;
#(
  parameter int KEY_WINDOW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_acc_i,
  input  logic key_ok_i,
  input  logic consume_i,
  output logic open_o
);

  localparam int CW = $clog2(KEY_WINDOW + 1);
  localparam logic [CW-1:0] RELOAD = CW'(KEY_WINDOW - 1);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KEY_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      KEY_IDLE: begin
        if (key_acc_i && key_ok_i) begin
          state_d = KEY_OPEN;
          cnt_d   = RELOAD;
        end
      end
      KEY_OPEN: begin
        // A key write in the same cycle as a field write wins: good key re-arms.
        if (key_acc_i) begin
          if (key_ok_i) begin
            cnt_d = RELOAD;
          end else begin
            state_d = KEY_IDLE;
          end
        end else if (consume_i) begin
          state_d = KEY_IDLE;
        end else if (cnt_q == '0) begin
          state_d = KEY_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = KEY_IDLE;
    endcase
  end

  assign open_o = (state_q == KEY_OPEN);

endmodule

// File: rtl/rggen_bit_field_protected.sv
// Read-write bit field whose writes are gated by lock sources, enable sources
// or a key-unlock window, selected at elaboration time by PROTECT_MODE.
module rggen_bit_field_protected
  import rggen_protect_pkg::*;
#(
  parameter protect_mode_e    PROTECT_MODE  = PROTECT_LOCK,
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
  parameter int               SOURCES       = 1,
  parameter bit               STICKY_LOCK   = 1'b0,
  parameter logic [WIDTH-1:0] KEY_VALUE     = WIDTH'('h5A),
  parameter int               KEY_WINDOW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOURCES-1:0] i_lock_or_enable,
  input  logic               i_command_valid,
  input  logic               i_select,
  input  logic               i_key_select,
  input  logic               i_write,
  input  logic [WIDTH-1:0]   i_write_data,
  input  logic [WIDTH-1:0]   i_write_mask,
  output logic [WIDTH-1:0]   o_value,
  output logic               o_unlocked,
  output logic               o_write_blocked
);

  logic             wr_acc;
  logic             unlocked;
  logic             wr_allowed;
  logic [WIDTH-1:0] value_q, value_d;
  logic             blocked_q;

  assign wr_acc = i_command_valid & i_select & i_write;

  generate
    if (PROTECT_MODE == PROTECT_KEY) begin : g_key
      logic key_acc;
      logic key_ok;
      logic key_open;
      logic unused_lock_cfg;

      assign key_acc = i_command_valid & i_key_select & i_write;
      assign key_ok  = (i_write_mask == '1) && (i_write_data == KEY_VALUE);

      rggen_key_window #(
        .KEY_WINDOW (KEY_WINDOW)
      ) u_key_window (
        .clk       (clk),
        .rst       (rst),
        .key_acc_i (key_acc),
        .key_ok_i  (key_ok),
        .consume_i (wr_acc),
        .open_o    (key_open)
      );

      assign unlocked        = key_open;
      assign unused_lock_cfg = ^{i_lock_or_enable, STICKY_LOCK};
    end else begin : g_src
      logic unused_key_cfg;
      assign unused_key_cfg = ^{i_key_select, KEY_VALUE, 8'(KEY_WINDOW)};

      if (PROTECT_MODE == PROTECT_ENABLE) begin : g_enable
        assign unlocked = &i_lock_or_enable;
      end else if (STICKY_LOCK) begin : g_sticky
        logic sticky_q;
        always_ff @(posedge clk) begin
          if (rst) begin
            sticky_q <= 1'b0;
          end else if (|i_lock_or_enable) begin
            sticky_q <= 1'b1;
          end
        end
        // Current-cycle lock counts too, so a lock arriving with a write blocks it.
        assign unlocked = ~(|i_lock_or_enable | sticky_q);
      end else begin : g_lock
        assign unlocked = ~(|i_lock_or_enable);
      end
    end
  endgenerate

  assign wr_allowed = wr_acc & unlocked;

  always_comb begin
    value_d = value_q;
    if (wr_allowed) begin
      value_d = WIDTH'(get_masked_write(64'(value_q), 64'(i_write_data), 64'(i_write_mask)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q   <= INITIAL_VALUE;
      blocked_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      blocked_q <= wr_acc & ~unlocked;
    end
  end

  assign o_value         = value_q;
  assign o_unlocked      = unlocked;
  assign o_write_blocked = blocked_q;

endmodule

// File: tb/tb_rggen_bit_field_protected.sv
// Four field instances (lock, sticky lock, enable, key) share one bus and are
// compared every cycle against a cycle-level model, plus directed literal checks.
module tb_rggen_bit_field_protected;

  logic       clk;
  logic       rst;
  logic       cv, sel, ksel, wr;
  logic [7:0] wd, wm;
  logic [2:0] lk_lock;
  logic [1:0] lk_sticky;
  logic [1:0] en;

  logic [7:0] o_val [4];
  logic       o_unl [4];
  logic       o_blk [4];

  localparam logic [7:0] INIT0 = 8'h3C;
  localparam logic [7:0] INIT1 = 8'h00;
  localparam logic [7:0] INIT2 = 8'hC3;
  localparam logic [7:0] INIT3 = 8'h81;
  localparam int         KWIN  = 4;
  localparam logic [7:0] KEY   = 8'h5A;

  string      name [4] = '{"lock", "sticky", "enable", "key"};
  logic [7:0] m_init [4] = '{INIT0, INIT1, INIT2, INIT3};

  logic [7:0] m_val [4];
  logic       m_blk [4];
  logic       m_unl [4];
  logic       m_sticky;
  int         m_left;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  rggen_bit_field_protected #(
    .PROTECT_MODE (rggen_protect_pkg::PROTECT_LOCK), .WIDTH (8),
    .INITIAL_VALUE (INIT0), .SOURCES (3), .STICKY_LOCK (1'b0)
  ) u_lock (
    .clk (clk), .rst (rst), .i_lock_or_enable (lk_lock),
    .i_command_valid (cv), .i_select (sel), .i_key_select (1'b0), .i_write (wr),
    .i_write_data (wd), .i_write_mask (wm),
    .o_value (o_val[0]), .o_unlocked (o_unl[0]), .o_write_blocked (o_blk[0])
  );

  rggen_bit_field_protected #(
    .PROTECT_MODE (rggen_protect_pkg::PROTECT_LOCK), .WIDTH (8),
    .INITIAL_VALUE (INIT1), .SOURCES (2), .STICKY_LOCK (1'b1)
  ) u_sticky (
    .clk (clk), .rst (rst), .i_lock_or_enable (lk_sticky),
    .i_command_valid (cv), .i_select (sel), .i_key_select (1'b0), .i_write (wr),
    .i_write_data (wd), .i_write_mask (wm),
    .o_value (o_val[1]), .o_unlocked (o_unl[1]), .o_write_blocked (o_blk[1])
  );

  rggen_bit_field_protected #(
    .PROTECT_MODE (rggen_protect_pkg::PROTECT_ENABLE), .WIDTH (8),
    .INITIAL_VALUE (INIT2), .SOURCES (2)
  ) u_enable (
    .clk (clk), .rst (rst), .i_lock_or_enable (en),
    .i_command_valid (cv), .i_select (sel), .i_key_select (1'b0), .i_write (wr),
    .i_write_data (wd), .i_write_mask (wm),
    .o_value (o_val[2]), .o_unlocked (o_unl[2]), .o_write_blocked (o_blk[2])
  );

  rggen_bit_field_protected #(
    .PROTECT_MODE (rggen_protect_pkg::PROTECT_KEY), .WIDTH (8),
    .INITIAL_VALUE (INIT3), .SOURCES (1), .KEY_VALUE (KEY), .KEY_WINDOW (KWIN)
  ) u_key (
    .clk (clk), .rst (rst), .i_lock_or_enable (1'b0),
    .i_command_valid (cv), .i_select (sel), .i_key_select (ksel), .i_write (wr),
    .i_write_data (wd), .i_write_mask (wm),
    .o_value (o_val[3]), .o_unlocked (o_unl[3]), .o_write_blocked (o_blk[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: m_left counts the write-allowed cycles still remaining in the key window.
  task automatic model_update();
    logic wr_acc, key_acc;
    logic ok [4];
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_val[i] = m_init[i];
        m_blk[i] = 1'b0;
      end
      m_sticky = 1'b0;
      m_left   = 0;
    end else begin
      wr_acc  = cv & sel & wr;
      key_acc = cv & ksel & wr;
      ok[0] = (lk_lock == 3'b000);
      ok[1] = (lk_sticky == 2'b00) && !m_sticky;
      ok[2] = (en == 2'b11);
      ok[3] = (m_left > 0);
      for (int i = 0; i < 4; i++) begin
        if (wr_acc && ok[i]) m_val[i] = (m_val[i] & ~wm) | (wd & wm);
        m_blk[i] = wr_acc && !ok[i];
      end
      if (lk_sticky != 2'b00) m_sticky = 1'b1;
      if (key_acc)                  m_left = (wm == 8'hFF && wd == KEY) ? KWIN : 0;
      else if (wr_acc && m_left > 0) m_left = 0;
      else if (m_left > 0)           m_left = m_left - 1;
    end
    m_unl[0] = (lk_lock == 3'b000);
    m_unl[1] = (lk_sticky == 2'b00) && !m_sticky;
    m_unl[2] = (en == 2'b11);
    m_unl[3] = (m_left > 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    for (int i = 0; i < 4; i++) begin
      check({name[i], "_value"},   o_val[i],       m_val[i]);
      check({name[i], "_blocked"}, 8'(o_blk[i]),   8'(m_blk[i]));
      check({name[i], "_unlocked"}, 8'(o_unl[i]),  8'(m_unl[i]));
    end
  endtask

  task automatic bus(input logic c, input logic s, input logic k, input logic w,
                     input logic [7:0] d, input logic [7:0] m);
    cv = c; sel = s; ksel = k; wr = w; wd = d; wm = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus(0, 0, 0, 0, 8'h00, 8'h00);
    step();
    rst = 1'b0;
  endtask

  initial begin
    lk_lock = '0; lk_sticky = '0; en = 2'b11;
    m_sticky = 1'b0; m_left = 0;
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 8'h00; m_blk[i] = 1'b0; m_unl[i] = 1'b0;
    end
    do_reset();
    check("rst_lock_value", o_val[0], 8'h3C);
    check("rst_key_value",  o_val[3], 8'h81);
    check("rst_lock_unl",   8'(o_unl[0]), 8'h01);
    check("rst_key_unl",    8'(o_unl[3]), 8'h00);
    check("rst_blocked",    8'(o_blk[0]), 8'h00);

    // LOCK: one of three sources high blocks the write
    lk_lock = 3'b010;
    bus(1, 1, 0, 1, 8'hAA, 8'hFF); step();
    check("lock_hold",    o_val[0], 8'h3C);
    check("lock_blk",     8'(o_blk[0]), 8'h01);
    lk_lock = 3'b000;
    step();
    check("lock_write",   o_val[0], 8'hAA);
    check("lock_noblk",   8'(o_blk[0]), 8'h00);

    // ENABLE: all sources must be high
    do_reset();
    en = 2'b01;
    bus(1, 1, 0, 1, 8'h0F, 8'h0C); step();
    check("en_hold",  o_val[2], 8'hC3);
    check("en_blk",   8'(o_blk[2]), 8'h01);
    en = 2'b11;
    step();
    check("en_masked", o_val[2], 8'hCF);
    check("en_noblk",  8'(o_blk[2]), 8'h00);

    // Sticky lock survives source release until reset
    do_reset();
    lk_sticky = 2'b01;
    bus(0, 0, 0, 0, 8'h00, 8'h00); step();
    lk_sticky = 2'b00;
    step();
    check("sticky_unl", 8'(o_unl[1]), 8'h00);
    bus(1, 1, 0, 1, 8'h11, 8'hFF); step();
    check("sticky_hold", o_val[1], 8'h00);
    check("sticky_blk",  8'(o_blk[1]), 8'h01);
    do_reset();
    bus(1, 1, 0, 1, 8'h11, 8'hFF); step();
    check("sticky_after_rst", o_val[1], 8'h11);

    // KEY: write on last window cycle accepted, window single-shot
    do_reset();
    bus(1, 0, 1, 1, KEY, 8'hFF); step();
    check("key_open", 8'(o_unl[3]), 8'h01);
    bus(0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < KWIN - 1; i++) step();
    bus(1, 1, 0, 1, 8'h33, 8'hFF); step();
    check("key_last_cycle", o_val[3], 8'h33);
    check("key_closed",     8'(o_unl[3]), 8'h00);
    bus(1, 1, 0, 1, 8'h44, 8'hFF); step();
    check("key_single_shot", 8'(o_blk[3]), 8'h01);
    bus(1, 0, 1, 1, KEY, 8'hFF); step();
    bus(0, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < KWIN; i++) step();
    bus(1, 1, 0, 1, 8'h55, 8'hFF); step();
    check("key_expired_blk", 8'(o_blk[3]), 8'h01);
    check("key_expired_val", o_val[3], 8'h33);
    bus(1, 0, 1, 1, 8'h5B, 8'hFF); step();
    check("key_bad_data", 8'(o_unl[3]), 8'h00);
    bus(1, 0, 1, 1, KEY, 8'h7F); step();
    check("key_bad_mask", 8'(o_unl[3]), 8'h00);
    bus(1, 1, 1, 1, KEY, 8'hFF); step();
    check("key_same_cycle_blk", 8'(o_blk[3]), 8'h01);
    check("key_same_cycle_unl", 8'(o_unl[3]), 8'h01);
    bus(1, 1, 0, 0, 8'h00, 8'hFF); step();
    check("key_read_keeps", 8'(o_unl[3]), 8'h01);
    bus(1, 1, 0, 1, 8'hFF, 8'h00); step();
    check("key_mask0_val", o_val[3], 8'h33);
    check("key_mask0_used", 8'(o_unl[3]), 8'h00);

    // Reset dominates a pending write in an open window
    bus(1, 0, 1, 1, KEY, 8'hFF); step();
    rst = 1'b1;
    bus(1, 1, 0, 1, 8'h77, 8'hFF); step();
    rst = 1'b0;
    check("rst_open_val", o_val[3], 8'h81);
    check("rst_open_unl", 8'(o_unl[3]), 8'h00);
    check("rst_open_blk", 8'(o_blk[3]), 8'h00);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 7));
      cv   = ($urandom_range(0, 3) != 0);
      sel  = (r < 4);
      ksel = (r >= 3 && r < 6);
      wr   = ($urandom_range(0, 3) != 0);
      wd   = (ksel && $urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
      wm   = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
      lk_lock   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      lk_sticky = ($urandom_range(0, 63) == 0) ? 2'($urandom) : 2'b00;
      en        = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      rst       = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
